// File: rtl/ram_port_arbiter.sv
// Shares one fixed-latency synchronous RAM port between instruction fetch and the MEM-stage data port.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests instead of data-first priority.
module ram_port_arbiter #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned RAM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic [DATA_W-1:0]     if_rdata,
   output logic                  if_valid,
   input  logic                  d_req,
   input  logic [DATA_W/8-1:0]   d_wen,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [DATA_W-1:0]     d_wdata,
   output logic [DATA_W-1:0]     d_rdata,
   output logic                  d_valid,
   output logic                  ram_en,
   output logic [DATA_W/8-1:0]   ram_wen,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic [DATA_W-1:0]     ram_wdata,
   input  logic [DATA_W-1:0]     ram_rdata,
   output logic                  stall_req
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned CNT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                gnt_data_q, gnt_data_d;
   logic                is_wr_q, is_wr_d;
   logic                ram_en_q, ram_en_d;
   logic [BE_W-1:0]     ram_wen_q, ram_wen_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                if_valid_q, if_valid_d;
   logic                d_valid_q, d_valid_d;
   logic                pick_data_c;

`ifdef ARB_ROUND_ROBIN_EN
   // 1 = data was granted last; reset value favours data on the first tie
   logic last_data_q, last_data_d;

   assign pick_data_c = d_req & (~if_req | ~last_data_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_data_q <= 1'b0;
      end else begin
         last_data_q <= last_data_d;
      end
   end

   always_comb begin
      last_data_d = last_data_q;
      if ((state_q == IDLE) && (if_req || d_req)) begin
         last_data_d = pick_data_c;
      end
   end
`else
   assign pick_data_c = d_req;
`endif

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         gnt_data_q  <= 1'b0;
         is_wr_q     <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_wen_q   <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_valid_q  <= 1'b0;
         d_valid_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gnt_data_q  <= gnt_data_d;
         is_wr_q     <= is_wr_d;
         ram_en_q    <= ram_en_d;
         ram_wen_q   <= ram_wen_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_valid_q  <= if_valid_d;
         d_valid_q   <= d_valid_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      gnt_data_d  = gnt_data_q;
      is_wr_d     = is_wr_q;
      ram_en_d    = 1'b0;
      ram_wen_d   = '0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_valid_d  = 1'b0;
      d_valid_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (if_req || d_req) begin
               gnt_data_d = pick_data_c;
               ram_en_d   = 1'b1;
               state_d    = ACCESS;
               if (pick_data_c) begin
                  is_wr_d     = |d_wen;
                  ram_wen_d   = d_wen;
                  ram_addr_d  = d_addr;
                  ram_wdata_d = d_wdata;
               end else begin
                  is_wr_d     = 1'b0;
                  ram_wen_d   = '0;
                  ram_addr_d  = if_addr;
                  ram_wdata_d = '0;
               end
            end
         end
         ACCESS: begin
            cnt_d   = CNT_W'(RAM_LATENCY - 1);
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
               if (gnt_data_q) begin
                  d_rdata_d = is_wr_q ? '0 : ram_rdata;
                  d_valid_d = 1'b1;
               end else begin
                  if_rdata_d = ram_rdata;
                  if_valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign if_rdata  = if_rdata_q;
   assign if_valid  = if_valid_q;
   assign d_rdata   = d_rdata_q;
   assign d_valid   = d_valid_q;
   assign ram_en    = ram_en_q;
   assign ram_wen   = ram_wen_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;

   // Held while reset is asserted so every output reads 0 during reset
   assign stall_req = rst & ((if_req & ~if_valid_q) | (d_req & ~d_valid_q));

endmodule
